// File: rtl/contra_rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : contra_rom_arbiter
// Purpose  : Round-robin arbiter sharing one synchronous tile/sprite ROM
//            between several pixel requesters. One grant per clock; the
//            returned palette index is steered back to its owner after the
//            ROM latency through a small tag pipeline.
// Revision : 1.0 - initial release
// ============================================================================
module contra_rom_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 15,
  parameter int DATA_W  = 5,
  parameter int ROM_LAT = 1
) (
  input  logic                      vga_clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [ADDR_W-1:0]         rom_address,
  input  logic [DATA_W-1:0]         rom_q,
  output logic [NUM_REQ-1:0]        rd_valid,
  output logic [DATA_W-1:0]         rd_data
);

  localparam int                 c_IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [c_IDX_W:0]   c_NUM_REQ = (c_IDX_W+1)'(NUM_REQ);
  localparam logic [c_IDX_W-1:0] c_LAST    = c_IDX_W'(NUM_REQ - 1);
  localparam logic [c_IDX_W-1:0] c_ONE     = c_IDX_W'(1);

  // Round-robin pointer: the requester examined first this cycle.
  logic [c_IDX_W-1:0] r_ptr;

  // Tag pipeline: one stage per cycle of ROM latency.
  logic [ROM_LAT-1:0] r_tag_vld;
  logic [c_IDX_W-1:0] r_tag_idx [ROM_LAT];

  // Arbitration results.
  logic               w_any;
  logic [c_IDX_W-1:0] w_win_idx;
  logic [c_IDX_W:0]   w_cand;

  // Scan from the pointer, wrapping; walk offsets from farthest to nearest
  // so the nearest requesting index is the one left standing.
  always_comb begin
    w_any     = 1'b0;
    w_win_idx = '0;
    w_cand    = '0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      w_cand = {1'b0, r_ptr} + (c_IDX_W+1)'(off);
      if (w_cand >= c_NUM_REQ) begin
        w_cand = w_cand - c_NUM_REQ;
      end
      if (req[w_cand[c_IDX_W-1:0]]) begin
        w_any     = 1'b1;
        w_win_idx = w_cand[c_IDX_W-1:0];
      end
    end
  end

  // Grant and ROM address are forced idle while reset is asserted.
  always_comb begin
    gnt         = '0;
    rom_address = '0;
    if (!reset && w_any) begin
      gnt[w_win_idx] = 1'b1;
      rom_address    = req_addr[w_win_idx*ADDR_W +: ADDR_W];
    end
  end

  // Pointer advances past the winner; it holds when nobody asks.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (w_any) begin
      r_ptr <= (w_win_idx == c_LAST) ? '0 : (w_win_idx + c_ONE);
    end
  end

  // Tag pipeline shifts every cycle; reset drops every in-flight read.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      r_tag_vld <= '0;
      for (int i = 0; i < ROM_LAT; i++) begin
        r_tag_idx[i] <= '0;
      end
    end else begin
      r_tag_vld[0] <= w_any;
      r_tag_idx[0] <= w_win_idx;
      for (int i = 1; i < ROM_LAT; i++) begin
        r_tag_vld[i] <= r_tag_vld[i-1];
        r_tag_idx[i] <= r_tag_idx[i-1];
      end
    end
  end

  // Decode the oldest tag into a one-hot return strobe.
  generate
    for (genvar k = 0; k < NUM_REQ; k++) begin : g_rd_valid
      assign rd_valid[k] = !reset && r_tag_vld[ROM_LAT-1] &&
                           (r_tag_idx[ROM_LAT-1] == c_IDX_W'(k));
    end
  endgenerate

  assign rd_data = rom_q;

endmodule
`default_nettype wire

// File: doc/contra_rom_arbiter.md
# contra_rom_arbiter

Round-robin arbiter sharing one synchronous tile/sprite ROM between several pixel requesters (background mapper, player sprite, enemy sprites) in the VGA rendering path. Grants one read per clock, drives the shared ROM address and routes the returned palette index back to the owning requester after the ROM latency. Sits between the per-layer mappers and the single ROM instance; the palette lookup stays on the requester side.

## Interface
- NUM_REQ, 3, number of requesters (2..8)
- ADDR_W, 15, ROM address width
- DATA_W, 5, ROM word width (palette index)
- ROM_LAT, 1, ROM read latency in cycles (1..3)

- vga_clk  in  1  sole clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- req  in  NUM_REQ  per-requester read request; held high until granted
- req_addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at bits [i*ADDR_W +: ADDR_W]; stable while req[i] high
- gnt  out  NUM_REQ  one-hot grant, combinational, same cycle as accepted request
- rom_address  out  ADDR_W  address to shared ROM, combinational
- rom_q  in  DATA_W  ROM output, valid ROM_LAT cycles after address presented
- rd_valid  out  NUM_REQ  one-hot, marks rd_data belonging to requester i
- rd_data  out  DATA_W  returned word, equals rom_q

## Operation
- Single state: round-robin pointer ptr (0..NUM_REQ-1), plus ROM_LAT-deep tag pipeline (valid bit + requester index per stage).
- Arbitration each cycle: scan requesters starting at ptr, wrapping modulo NUM_REQ; first i with req[i]=1 wins.
- Winner: gnt[i]=1, rom_address=req_addr slice i, stage-0 tag loaded with {1, i}; ptr <= (i+1) mod NUM_REQ.
- No request: gnt=0, rom_address=0, stage-0 tag loaded with valid=0, ptr unchanged.
- At most one gnt bit high per cycle; gnt never asserted for a requester with req low.
- Tag pipeline shifts every cycle; no back-pressure — requesters must accept rd_valid data in the cycle it appears.
- rd_valid[k]=1 iff last pipeline stage valid and its index equals k; rd_data=rom_q unconditionally (don't-care when rd_valid=0).
- Requester handshake: after gnt[i], requester may drop req[i] or present a new address with req[i] still high next cycle (treated as new request, subject to round-robin).
- Fairness: with all requesters continuously requesting, grants rotate 0,1,…,NUM_REQ-1; any requester waits at most NUM_REQ-1 cycles for gnt.

## Timing
- Reset (cycle with reset=1, evaluated at edge): ptr=0, all tag stages valid=0. During reset cycle gnt=0, rom_address=0, rd_valid=0 regardless of req.
- First cycle after reset: arbitration starts at requester 0.
- Request accepted in cycle T → rom_address presented in T → rd_valid/rd_data in cycle T+ROM_LAT.
- Throughput: one grant per cycle, back-to-back grants to different or same requester allowed.
- Reset mid-operation: all in-flight reads discarded; no rd_valid for reads granted before reset, even if ROM returns data.
- Simultaneous req and reset: reset wins, no grant, ptr=0.
- Requester whose req drops before being granted: no grant, no rd_valid generated.
- ptr wrap: grant to NUM_REQ-1 sets ptr=0.

## Test plan
- Reset check: hold reset 2 cycles with req=3'b111 → gnt=0, rom_address=0, rd_valid=0; first cycle after reset with req=3'b111 → gnt=3'b001.
- Single requester: req=3'b010, req_addr[1]=15'h1234, ROM word at 0x1234 = 5'd17 → gnt=3'b010 in T, rom_address=0x1234 in T, rd_valid=3'b010 and rd_data=17 in T+1 (ROM_LAT=1).
- Full contention: req=3'b111 held 6 cycles, distinct addresses → gnt sequence 001,010,100,001,010,100; rd_valid same sequence delayed 1 cycle with matching data.
- Wrap/skip: ptr=2 (after grant to 1), req=3'b011 → gnt=3'b001 (2 skipped, wraps to 0), next cycle gnt=3'b010.
- Idle gap: req=0 for 3 cycles between grants → gnt=0, rom_address=0, rd_valid=0 during gap; ptr preserved across gap.
- Reset mid-flight with ROM_LAT=3: grants in T, T+1, then reset at T+2 → no rd_valid in T+3..T+5; first post-reset grant goes to lowest-index requesting port.
